// File: rtl/linear_network_collect_pipe.sv
// Daisy-chained collection pipe: NUM_NODE registered stages gather words from local
// nodes toward stage 0, tagging each word with the index of the node that produced it.
module linear_network_collect_pipe #(
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_NODE   = 4,
  localparam int SRC_WIDTH  = ($clog2(NUM_NODE) < 1) ? 1 : $clog2(NUM_NODE)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_en,
  input  logic [NUM_NODE-1:0]            i_valid,
  input  logic [DATA_WIDTH*NUM_NODE-1:0] i_data_bus,
  output logic [NUM_NODE-1:0]            o_ready,
  output logic                           o_valid,
  output logic [DATA_WIDTH-1:0]          o_data_bus,
  output logic [SRC_WIDTH-1:0]           o_src,
  input  logic                           i_ready
);

  logic [NUM_NODE-1:0]   valid_q, valid_d;
  logic [NUM_NODE-1:0]   fair_q, fair_d;
  logic [DATA_WIDTH-1:0] data_q [NUM_NODE];
  logic [DATA_WIDTH-1:0] data_d [NUM_NODE];
  logic [SRC_WIDTH-1:0]  src_q  [NUM_NODE];
  logic [SRC_WIDTH-1:0]  src_d  [NUM_NODE];

  logic [NUM_NODE-1:0]   up_valid;
  logic [DATA_WIDTH-1:0] up_data [NUM_NODE];
  logic [SRC_WIDTH-1:0]  up_src  [NUM_NODE];

  logic [NUM_NODE-1:0]   free;
  logic [NUM_NODE-1:0]   grant_up;
  logic [NUM_NODE-1:0]   grant_loc;
  logic                  take;

  always_comb begin
    up_valid = '0;
    for (int k = 0; k < NUM_NODE; k++) begin
      up_data[k] = '0;
      up_src[k]  = '0;
    end
    for (int k = 0; k < NUM_NODE - 1; k++) begin
      up_valid[k] = valid_q[k+1];
      up_data[k]  = data_q[k+1];
      up_src[k]   = src_q[k+1];
    end
  end

  // The drain of stage k is the upstream grant of stage k-1, so the chain is walked from
  // the output end; 'take' carries that drain from one stage to the next.
  always_comb begin
    free      = '0;
    grant_up  = '0;
    grant_loc = '0;
    take      = i_en & valid_q[0] & i_ready;
    for (int k = 0; k < NUM_NODE; k++) begin
      free[k]      = ~valid_q[k] | take;
      grant_up[k]  = i_en & free[k] & up_valid[k] & (~i_valid[k] | ~fair_q[k]);
      grant_loc[k] = i_en & free[k] & i_valid[k] & (~up_valid[k] | fair_q[k]);
      take         = grant_up[k];
    end
  end

  assign o_ready = grant_loc;

  always_comb begin
    valid_d = valid_q;
    fair_d  = fair_q;
    for (int k = 0; k < NUM_NODE; k++) begin
      data_d[k] = data_q[k];
      src_d[k]  = src_q[k];
      if (grant_up[k]) begin
        valid_d[k] = 1'b1;
        data_d[k]  = up_data[k];
        src_d[k]   = up_src[k];
      end else if (grant_loc[k]) begin
        valid_d[k] = 1'b1;
        data_d[k]  = i_data_bus[k*DATA_WIDTH +: DATA_WIDTH];
        src_d[k]   = SRC_WIDTH'(k);
      end else if (i_en && free[k]) begin
        valid_d[k] = 1'b0;
        data_d[k]  = '0;
        src_d[k]   = '0;
      end
      if (i_en && free[k] && up_valid[k] && i_valid[k]) begin
        fair_d[k] = ~fair_q[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      fair_q  <= '0;
      for (int k = 0; k < NUM_NODE; k++) begin
        data_q[k] <= '0;
        src_q[k]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      fair_q  <= fair_d;
      for (int k = 0; k < NUM_NODE; k++) begin
        data_q[k] <= data_d[k];
        src_q[k]  <= src_d[k];
      end
    end
  end

  assign o_valid    = valid_q[0];
  assign o_data_bus = valid_q[0] ? data_q[0] : '0;
  assign o_src      = valid_q[0] ? src_q[0] : '0;

endmodule
